// File: rtl/game_pkg.sv
// Shared game encodings and limits for the goose/bean collision controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam logic [9:0]  V_ACTIVE  = 10'd480;
  localparam logic [13:0] SCORE_MAX = 14'd9999;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for the start button followed by a registered
// rising-edge detector; pulse is one clk wide.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
      pulse <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/collision_ctrl.sv
// Game controller: per-frame goose/bean overlap detection, game FSM, score
// and high score, plus freeze/restart controls for the obstacle renderer.
//
//   state | meaning
//   IDLE  | waiting for the first start press after reset
//   RUN   | game active, clean frames advance the score
//   HIT   | hit-stop freeze, obstacles frozen for HIT_FRAMES frames
//   OVER  | game ended, score held, waiting for a restart press
module collision_ctrl
  import game_pkg::*;
#(
  parameter int HIT_THRESH = 4,
  parameter int HIT_FRAMES = 30,
  parameter int SCORE_DIV  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        goose,
  input  logic        bean,
  input  logic        start_btn,
  output logic        check_hit,
  output logic        game_rst,
  output logic [1:0]  state,
  output logic [13:0] score,
  output logic [13:0] hi_score
);

  localparam int HW = $clog2(HIT_FRAMES + 1);
  localparam int DW = $clog2(SCORE_DIV + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(HIT_FRAMES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCORE_DIV - 1);
  localparam logic [3:0]    THRESH   = 4'(HIT_THRESH);

  game_state_t   st;
  logic          start_pulse;
  logic [9:0]    y_q;
  logic [3:0]    ovl_cnt;
  logic [3:0]    ovl_total;
  logic [HW-1:0] hit_left;
  logic [DW-1:0] div_left;
  logic          frame_tick;
  logic          ovl_px;
  logic          x_unused;

  btn_edge u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (start_btn),
    .pulse (start_pulse)
  );

  // Column position does not matter for overlap counting.
  assign x_unused   = ^x;
  assign frame_tick = pix_en && (y == V_ACTIVE) && (y_q != V_ACTIVE);
  assign ovl_px     = pix_en & video_on & goose & bean;
  // Includes the current pixel so an overlap on the tick cycle still counts.
  assign ovl_total  = (ovl_px && (ovl_cnt != 4'hF)) ? ovl_cnt + 4'd1 : ovl_cnt;
  assign state      = st;

  always_ff @(posedge clk) begin
    if (!reset) begin
      y_q <= '0;
    end else if (pix_en) begin
      y_q <= y;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      check_hit <= 1'b0;
      game_rst  <= 1'b0;
      score     <= '0;
      hi_score  <= '0;
      ovl_cnt   <= '0;
      hit_left  <= '0;
      div_left  <= '0;
    end else begin
      game_rst <= 1'b0;
      if (frame_tick) begin
        ovl_cnt <= '0;
      end else if (st == RUN) begin
        ovl_cnt <= ovl_total;
      end

      case (st)
        IDLE, OVER: begin
          if (start_pulse) begin
            st        <= RUN;
            game_rst  <= 1'b1;
            check_hit <= 1'b0;
            score     <= '0;
            div_left  <= DIV_LAST;
            ovl_cnt   <= '0;
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (ovl_total >= THRESH) begin
              st        <= HIT;
              check_hit <= 1'b1;
              hit_left  <= HIT_LAST;
            end else if (div_left == '0) begin
              div_left <= DIV_LAST;
              if (score != SCORE_MAX) score <= score + 14'd1;
            end else begin
              div_left <= div_left - 1'b1;
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (hit_left == '0) begin
              st <= OVER;
              if (score > hi_score) hi_score <= score;
            end else begin
              hit_left <= hit_left - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_ctrl.sv
// Bench for collision_ctrl: reset/start table, directed game sequences and
// randomized pixel streams compared every cycle against a frame-level model.
module tb_collision_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        goose;
  logic        bean;
  logic        start_btn;
  logic        check_hit;
  logic        game_rst;
  logic [1:0]  state;
  logic [13:0] score;
  logic [13:0] hi_score;

  always #5 clk = ~clk;

  collision_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .x         (x),
    .y         (y),
    .video_on  (video_on),
    .goose     (goose),
    .bean      (bean),
    .start_btn (start_btn),
    .check_hit (check_hit),
    .game_rst  (game_rst),
    .state     (state),
    .score     (score),
    .hi_score  (hi_score)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: game phase 0..3, clean frames since start, frames spent frozen.
  int m_state, m_chk, m_grst, m_score, m_hi;
  int m_ovl, m_clean, m_hitcnt, m_yprev;
  bit btn_hist[$];

  typedef struct {
    bit rst;
    bit btn;
    int st;
    int grst;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_chk = 0; m_grst = 0; m_score = 0; m_hi = 0;
    m_ovl = 0; m_clean = 0; m_hitcnt = 0; m_yprev = 0;
  endtask

  // A press is acted on when the sample three edges back is high and the one
  // before it low.
  task automatic model_edge();
    int sz;
    bit start_ev, tick, px;
    sz = btn_hist.size();
    start_ev = btn_hist[sz-3] && !btn_hist[sz-4];
    tick = pix_en && (y == 10'd480) && (m_yprev != 480);
    px = pix_en && video_on && goose && bean;
    if (!reset) begin
      model_reset();
      btn_hist.push_back(1'b0);
    end else begin
      m_grst = 0;
      case (m_state)
        0, 3: if (start_ev) begin
          m_state = 1; m_grst = 1; m_chk = 0; m_score = 0; m_clean = 0; m_ovl = 0;
        end
        1: if (tick) begin
          if (m_ovl + int'(px) >= 4) begin
            m_state = 2; m_chk = 1; m_hitcnt = 0;
          end else begin
            m_clean++;
            m_score = (m_clean / 6 > 9999) ? 9999 : m_clean / 6;
          end
          m_ovl = 0;
        end else if (px) begin
          m_ovl++;
        end
        2: if (tick) begin
          m_hitcnt++;
          if (m_hitcnt == 30) begin
            m_state = 3;
            if (m_score > m_hi) m_hi = m_score;
          end
        end
        default: ;
      endcase
      if (pix_en) m_yprev = int'(y);
      btn_hist.push_back(start_btn);
    end
    if (btn_hist.size() > 8) void'(btn_hist.pop_front());
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("state", state, m_state);
    check("check_hit", check_hit, m_chk);
    check("game_rst", game_rst, m_grst);
    check("score", score, m_score);
    check("hi_score", hi_score, m_hi);
  endtask

  task automatic idle_cyc();
    pix_en = 0; video_on = 0; goose = 0; bean = 0;
    cyc();
  endtask

  task automatic pixel(input int yy, input bit g, input bit b);
    pix_en = 1; y = 10'(yy); x = 10'd320; video_on = (yy < 480);
    goose = g; bean = b;
    cyc();
  endtask

  task automatic frame(input int n_ovl, input int n_plain);
    pixel(0, 0, 0);
    for (int i = 0; i < n_ovl; i++) pixel(100 + i, 1, 1);
    for (int i = 0; i < n_plain; i++) pixel(200 + i, 1, 0);
    pixel(480, 0, 0);
    idle_cyc();
  endtask

  task automatic press_start();
    start_btn = 1;
    repeat (4) idle_cyc();
    start_btn = 0;
    idle_cyc();
  endtask

  initial begin
    reset = 0; pix_en = 0; x = 0; y = 0; video_on = 0;
    goose = 0; bean = 0; start_btn = 0;
    repeat (4) btn_hist.push_back(1'b0);
    model_reset();

    // Reset then a held start press: one game_rst pulse with RUN on that cycle.
    tbl[0] = '{1'b0, 1'b0, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 0, 0};
    tbl[4] = '{1'b1, 1'b1, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 1, 1};
    tbl[6] = '{1'b1, 1'b1, 1, 0};
    tbl[7] = '{1'b1, 1'b1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst;
      start_btn = tbl[i].btn;
      idle_cyc();
      check("tbl_state", state, tbl[i].st);
      check("tbl_game_rst", game_rst, tbl[i].grst);
      check("tbl_check_hit", check_hit, 0);
      check("tbl_score", score, 0);
      check("tbl_hi_score", hi_score, 0);
    end
    start_btn = 0;

    // Twelve clean frames give two score increments.
    repeat (12) frame(0, 2);
    check("run12_score", score, 2);
    check("run12_check_hit", check_hit, 0);

    // Three overlaps stay below threshold; five cause a hit.
    frame(3, 1);
    check("ovl3_state", state, 1);
    pixel(0, 0, 0);
    repeat (5) pixel(100, 1, 1);
    check("pre_hit_chk", check_hit, 0);
    pixel(480, 0, 0);
    check("hit_state", state, 2);
    check("hit_chk", check_hit, 1);
    idle_cyc();

    // Freeze lasts 30 frame ticks, then OVER records the high score.
    repeat (29) frame(0, 0);
    check("hit29_state", state, 2);
    frame(0, 0);
    check("over_state", state, 3);
    check("over_hi", hi_score, 2);
    check("over_score", score, 2);

    // Second game ends with score 0 at exactly the threshold: hi_score holds.
    press_start();
    check("game2_state", state, 1);
    frame(4, 0);
    check("thresh4_state", state, 2);
    repeat (30) frame(0, 0);
    check("over2_state", state, 3);
    check("over2_hi", hi_score, 2);

    // Start pulse lands on the same cycle as a frame tick in OVER.
    start_btn = 1;
    repeat (3) pixel(10, 0, 0);
    pixel(480, 0, 0);
    check("coinc_state", state, 1);
    check("coinc_grst", game_rst, 1);
    check("coinc_chk", check_hit, 0);
    check("coinc_score", score, 0);
    start_btn = 0;
    idle_cyc();
    check("coinc_grst_end", game_rst, 0);

    // Reset in the middle of a RUN frame.
    repeat (2) frame(0, 0);
    pixel(0, 0, 0);
    repeat (2) pixel(100, 1, 1);
    reset = 0;
    idle_cyc();
    check("rst_state", state, 0);
    check("rst_hi", hi_score, 0);
    check("rst_chk", check_hit, 0);
    reset = 1;

    // Overlap on the tick pixel itself counts toward the ending frame.
    press_start();
    pixel(0, 0, 0);
    repeat (2) pixel(100, 1, 1);
    pix_en = 1; y = 10'd480; video_on = 1; goose = 1; bean = 1;
    cyc();
    check("tickovl3_state", state, 1);
    pixel(0, 0, 0);
    repeat (3) pixel(100, 1, 1);
    pix_en = 1; y = 10'd480; video_on = 1; goose = 1; bean = 1;
    cyc();
    check("tickovl4_state", state, 2);

    // Randomized pixel streams against the model.
    reset = 0;
    idle_cyc();
    reset = 1;
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 29) == 0) start_btn = ~start_btn;
      pix_en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: y = 10'd480;
        1: y = 10'd481;
        default: y = 10'($urandom_range(0, 479));
      endcase
      x = 10'($urandom_range(0, 639));
      video_on = (y < 10'd480) ^ ($urandom_range(0, 9) == 0);
      goose = $urandom_range(0, 1) == 0;
      bean = $urandom_range(0, 1) == 0;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
